// File: rtl/lf_meas_ctrl.sv
// Auto-scaled low-frequency counter sequencer: measures one si period in clk ticks,
// then drives an external divider (K/period, then /10 steps) down to a 4-digit result.
module lf_meas_ctrl #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned DW         = 40,
    parameter int unsigned PW         = 32,
    parameter int unsigned MAX_PERIOD = 100_000_000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          si,
    input  logic          div_ready,
    input  logic          div_done,
    input  logic [DW-1:0] div_quo,
    output logic          div_start,
    output logic [DW-1:0] div_dvnd,
    output logic [DW-1:0] div_dvsr,
    output logic          ready,
    output logic          done_tick,
    output logic [13:0]   bin,
    output logic [1:0]    dp_pos,
    output logic          err,
    output logic          ovf
);

    typedef enum logic [2:0] {IDLE, WAIT1, MEAS, DIV0, DWAIT, DIV10, DONE} state_t;

    localparam logic [DW-1:0] DVND_MHZ = DW'(64'(CLK_HZ) * 64'd1000);
    localparam logic [PW-1:0] CNT_MAX  = PW'(MAX_PERIOD);
    localparam logic [DW-1:0] BIN_MAX  = DW'(9999);

    state_t        state_q, state_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [1:0]    scale_q, scale_d;
    logic [DW-1:0] dvnd_q, dvnd_d;
    logic [DW-1:0] dvsr_q, dvsr_d;
    logic [13:0]   bin_q, bin_d;
    logic [1:0]    dp_q, dp_d;
    logic          err_q, err_d;
    logic          ovf_q, ovf_d;
    logic [2:0]    si_sync_q, st_sync_q;
    logic          si_rise, st_rise;

    // Two synchroniser flops, third flop for edge detection.
    assign si_rise = si_sync_q[1] & ~si_sync_q[2];
    assign st_rise = st_sync_q[1] & ~st_sync_q[2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            scale_q   <= '0;
            dvnd_q    <= '0;
            dvsr_q    <= '0;
            bin_q     <= '0;
            dp_q      <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
            si_sync_q <= '0;
            st_sync_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            scale_q   <= scale_d;
            dvnd_q    <= dvnd_d;
            dvsr_q    <= dvsr_d;
            bin_q     <= bin_d;
            dp_q      <= dp_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
            si_sync_q <= {si_sync_q[1:0], si};
            st_sync_q <= {st_sync_q[1:0], start};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        scale_d   = scale_q;
        dvnd_d    = dvnd_q;
        dvsr_d    = dvsr_q;
        bin_d     = bin_q;
        dp_d      = dp_q;
        err_d     = err_q;
        ovf_d     = ovf_q;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (st_rise) begin
                    state_d = WAIT1;
                    cnt_d   = '0;
                    scale_d = '0;
                    bin_d   = '0;
                    dp_d    = '0;
                    err_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            WAIT1: begin
                if (si_rise) begin
                    state_d = MEAS;
                    cnt_d   = PW'(1);
                end else if (cnt_q == CNT_MAX) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
            end
            MEAS: begin
                // A rise coinciding with the timeout still yields a valid period.
                if (si_rise) begin
                    state_d = DIV0;
                    dvnd_d  = DVND_MHZ;
                    dvsr_d  = DW'(cnt_q);
                end else if (cnt_q == CNT_MAX) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
            end
            DIV0: begin
                if (div_ready) begin
                    div_start = 1'b1;
                    state_d   = DWAIT;
                end
            end
            DWAIT: begin
                if (div_done) begin
                    if (div_quo <= BIN_MAX) begin
                        state_d = DONE;
                        bin_d   = div_quo[13:0];
                        dp_d    = scale_q;
                    end else if (scale_q == 2'd3) begin
                        state_d = DONE;
                        ovf_d   = 1'b1;
                        bin_d   = 14'd9999;
                        dp_d    = scale_q;
                    end else begin
                        state_d = DIV10;
                        dvnd_d  = div_quo;
                        dvsr_d  = DW'(10);
                    end
                end
            end
            DIV10: begin
                if (div_ready) begin
                    div_start = 1'b1;
                    scale_d   = scale_q + 2'd1;
                    state_d   = DWAIT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign div_dvnd  = dvnd_q;
    assign div_dvsr  = dvsr_q;
    assign ready     = (state_q == IDLE);
    assign done_tick = (state_q == DONE);
    assign bin       = bin_q;
    assign dp_pos    = dp_q;
    assign err       = err_q;
    assign ovf       = ovf_q;

endmodule
